// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: byte-to-serial overlapping Mealy pattern detector with hit/match counting.
// Define SEQ_DET_CTRL_CARRY_EN to keep detector history across bytes (stream mode).
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic clear,
  output logic bit_out,
  output logic bit_strobe,
  output logic match,
  output logic done,
  output logic [$clog2(DATA_W+1)-1:0] done_hits,
  output logic [CNT_W-1:0] match_cnt,
  output logic busy,
  output logic [2:0] q
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HW = $clog2(DATA_W+1);
  localparam int LW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] ILAST = IW'(DATA_W-1);
  localparam logic [LW-1:0] LMAX = LW'(PAT_W-1);
  typedef enum logic [2:0] {IDLE = 3'd0, SHIFT = 3'd1, DONE = 3'd2} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] data_r;
  logic [IW-1:0] idx;
  logic [HW-1:0] hits;
  logic [PAT_W-2:0] hist;
  logic [LW-1:0] hlen;
  logic [PAT_W-1:0] win;
  logic load;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bit_strobe = state == SHIFT;
  assign q = state;
  assign load = in_ready && in_valid;
  assign bit_out = bit_strobe && data_r[idx];
  assign win = {hist, bit_out};
  assign match = bit_strobe && !clear && hlen == LMAX && win == PATTERN;
  assign done_hits = done ? hits : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? SHIFT : IDLE;
      SHIFT: state_n = idx == '0 ? DONE : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      data_r <= '0;
      idx <= '0;
      hits <= '0;
      hist <= '0;
      hlen <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        data_r <= in_data;
        idx <= ILAST;
        hits <= '0;
`ifndef SEQ_DET_CTRL_CARRY_EN
        hist <= '0;
        hlen <= '0;
`endif
      end
      if (bit_strobe) begin
        idx <= idx - 1'b1;
        hist <= win[PAT_W-2:0];
        if (hlen != LMAX) hlen <= hlen + 1'b1;
        if (match) begin
          hits <= hits + 1'b1;
          if (~&match_cnt) match_cnt <= match_cnt + 1'b1;
        end
      end
      // clear wins over the shift so the current bit never enters history
      if (clear) begin
        hist <= '0;
        hlen <= '0;
        match_cnt <= '0;
      end
    end
  end
endmodule
